// File: rtl/blake2_ctrl.sv
// blake2_ctrl: job sequencer in front of the blake2 hash core.
// Takes one config beat plus a key/message byte stream, cuts it into
// zero-padded BB-byte blocks for the core, then strips the core's lead
// result cycles and re-emits exactly nn digest bytes.
//
// Optional feature macro: BLAKE2_CTRL_KEY_EN
//   defined   : keyed hashing (KEY state, kk latched, ll includes key block)
//   undefined : unkeyed only; core_kk_o = 0, any cfg_kk_i != 0 is rejected
//
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   cfg_v_i/kk/nn/mlen    job config beat (sampled only when idle)
//   cfg_slow_i            core presents each result byte for 2 cycles
//   cfg_err_o             one-cycle pulse when a config is rejected
//   s_valid_i/ready/data  input byte stream (key bytes, then message)
//   core_*_o              block framing and byte strobe into the core
//   core_ready_v_i        core can take a byte this cycle
//   core_h_v_i/core_h_i   core result window and result byte
//   h_v_o/h_o/h_last_o    digest byte stream out
//   busy_o                a job is in progress
module blake2_ctrl #(
    parameter int W          = 64,
    parameter int BB         = W * 2,
    parameter int LEN_W      = 32,
    parameter int BB_CLOG2   = $clog2(BB),
    parameter int W_CLOG2_P1 = $clog2(W + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cfg_v_i,
    input  logic [W_CLOG2_P1-1:0] cfg_kk_i,
    input  logic [W_CLOG2_P1-1:0] cfg_nn_i,
    input  logic [LEN_W-1:0]      cfg_mlen_i,
    input  logic                  cfg_slow_i,
    output logic                  cfg_err_o,
    input  logic                  s_valid_i,
    output logic                  s_ready_o,
    input  logic [7:0]            s_data_i,
    output logic                  core_nreset_o,
    output logic [W_CLOG2_P1-1:0] core_kk_o,
    output logic [W_CLOG2_P1-1:0] core_nn_o,
    output logic [BB-1:0]         core_ll_o,
    output logic                  core_slow_output_o,
    output logic                  core_block_first_o,
    output logic                  core_block_last_o,
    output logic                  core_data_v_o,
    output logic [BB_CLOG2-1:0]   core_data_idx_o,
    output logic [7:0]            core_data_o,
    input  logic                  core_ready_v_i,
    input  logic                  core_h_v_i,
    input  logic [7:0]            core_h_i,
    output logic                  h_v_o,
    output logic [7:0]            h_o,
    output logic                  h_last_o,
    output logic                  busy_o
);

    localparam logic [2:0] ST_IDLE = 3'd0;
`ifdef BLAKE2_CTRL_KEY_EN
    localparam logic [2:0] ST_KEY  = 3'd1;
`endif
    localparam logic [2:0] ST_MSG  = 3'd2;
    localparam logic [2:0] ST_WAIT = 3'd3;
    localparam logic [2:0] ST_LEAD = 3'd4;
    localparam logic [2:0] ST_OUT  = 3'd5;

    localparam logic [BB_CLOG2-1:0] IDX_LAST = BB_CLOG2'(BB - 1);
    localparam logic [LEN_W-1:0]    BB_LEN   = LEN_W'(BB);
`ifdef BLAKE2_CTRL_KEY_EN
    localparam logic [BB-1:0]       LL_KEY   = BB'(BB);
`endif

    logic [2:0]            state_q;
    logic [1:0]            nrst_q;
`ifdef BLAKE2_CTRL_KEY_EN
    logic [W_CLOG2_P1-1:0] kk_q;
`endif
    logic [W_CLOG2_P1-1:0] nn_q;
    logic [W_CLOG2_P1-1:0] ocnt_q;
    logic [BB-1:0]         ll_q;
    logic [LEN_W-1:0]      rem_q;
    logic [LEN_W-1:0]      rem_nxt;
    logic [BB_CLOG2-1:0]   idx_q;
    logic                  slow_q;
    logic                  first_q;
    logic                  last_q;
    logic                  phase_q;
    logic                  busy_q;
    logic                  err_q;
    logic                  hv_q;
    logic                  hlast_q;
    logic [7:0]            h_q;

    logic feeding;
    logic stream_src;
    logic xfer;
    logic cfg_bad;

    always_comb begin
        cfg_bad = (cfg_nn_i == '0) || (int'(cfg_nn_i) > W);
`ifdef BLAKE2_CTRL_KEY_EN
        cfg_bad = cfg_bad || (int'(cfg_kk_i) > W);
`else
        cfg_bad = cfg_bad || (cfg_kk_i != '0);
`endif
    end

    // Stream bytes feed the block while real data remains;
    // the rest of the block is zero padding that never touches the stream.
    always_comb begin
        stream_src = 1'b0;
        if (state_q == ST_MSG) begin
            stream_src = (rem_q != '0);
        end
`ifdef BLAKE2_CTRL_KEY_EN
        else if (state_q == ST_KEY) begin
            stream_src = (int'(idx_q) < int'(kk_q));
        end
`endif
    end

`ifdef BLAKE2_CTRL_KEY_EN
    assign feeding = (state_q == ST_KEY) || (state_q == ST_MSG);
`else
    assign feeding = (state_q == ST_MSG);
`endif

    assign xfer = feeding & core_ready_v_i & (~stream_src | s_valid_i);
    assign rem_nxt = ((state_q == ST_MSG) && stream_src) ? rem_q - 1'b1
                                                        : rem_q;

    assign s_ready_o     = feeding & core_ready_v_i & stream_src;
    assign core_data_v_o = xfer;
    assign core_data_o   = stream_src ? s_data_i : 8'h00;

    // Core reset is released two clocks after our own reset drops.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            nrst_q <= 2'b00;
        end else begin
            nrst_q <= {nrst_q[0], 1'b1};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
`ifdef BLAKE2_CTRL_KEY_EN
            kk_q    <= '0;
`endif
            nn_q    <= '0;
            ocnt_q  <= '0;
            ll_q    <= '0;
            rem_q   <= '0;
            idx_q   <= '0;
            slow_q  <= 1'b0;
            first_q <= 1'b0;
            last_q  <= 1'b0;
            phase_q <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
            hv_q    <= 1'b0;
            hlast_q <= 1'b0;
            h_q     <= 8'h00;
        end else begin
            err_q   <= 1'b0;
            hv_q    <= 1'b0;
            hlast_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (cfg_v_i) begin
                        if (cfg_bad) begin
                            err_q <= 1'b1;
                        end else begin
                            nn_q    <= cfg_nn_i;
                            slow_q  <= cfg_slow_i;
                            rem_q   <= cfg_mlen_i;
                            idx_q   <= '0;
                            ocnt_q  <= '0;
                            phase_q <= 1'b0;
                            first_q <= 1'b1;
                            busy_q  <= 1'b1;
`ifdef BLAKE2_CTRL_KEY_EN
                            kk_q    <= cfg_kk_i;
                            if (cfg_kk_i != '0) begin
                                state_q <= ST_KEY;
                                last_q  <= (cfg_mlen_i == '0);
                                ll_q    <= BB'(cfg_mlen_i) + LL_KEY;
                            end else
`endif
                            begin
                                // mlen==0 still sends one all-zero block
                                state_q <= ST_MSG;
                                last_q  <= (cfg_mlen_i <= BB_LEN);
                                ll_q    <= BB'(cfg_mlen_i);
                            end
                        end
                    end
                end
`ifdef BLAKE2_CTRL_KEY_EN
                ST_KEY,
`endif
                ST_MSG: begin
                    if (xfer) begin
                        idx_q <= idx_q + 1'b1;
                        rem_q <= rem_nxt;
                        if (idx_q == IDX_LAST) begin
                            first_q <= 1'b0;
                            if (last_q) begin
                                state_q <= ST_WAIT;
                            end else begin
                                state_q <= ST_MSG;
                                last_q  <= (rem_nxt <= BB_LEN);
                            end
                        end
                    end
                end
                ST_WAIT: begin
                    // First result cycle is always a lead cycle.
                    if (core_h_v_i) begin
                        state_q <= slow_q ? ST_LEAD : ST_OUT;
                        phase_q <= 1'b0;
                    end
                end
                ST_LEAD: begin
                    state_q <= ST_OUT;
                end
                ST_OUT: begin
                    // In slow mode only the first cycle of each pair counts.
                    phase_q <= slow_q & ~phase_q;
                    if (!phase_q) begin
                        hv_q   <= 1'b1;
                        h_q    <= core_h_i;
                        ocnt_q <= ocnt_q + 1'b1;
                        if (ocnt_q == nn_q - 1'b1) begin
                            hlast_q <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign cfg_err_o          = err_q;
    assign busy_o             = busy_q;
    assign core_nreset_o      = nrst_q[1];
`ifdef BLAKE2_CTRL_KEY_EN
    assign core_kk_o          = kk_q;
`else
    assign core_kk_o          = '0;
`endif
    assign core_nn_o          = nn_q;
    assign core_ll_o          = ll_q;
    assign core_slow_output_o = slow_q;
    assign core_block_first_o = first_q;
    assign core_block_last_o  = last_q;
    assign core_data_idx_o    = idx_q;
    assign h_v_o              = hv_q;
    assign h_o                = h_q;
    assign h_last_o           = hlast_q;

endmodule

// File: tb/tb_blake2_ctrl.sv
// tb_blake2_ctrl: self-checking bench for blake2_ctrl.
// Table of job configs plus random jobs against a block-level model.
module tb_blake2_ctrl;

    localparam int W  = 64;
    localparam int BB = 128;
`ifdef BLAKE2_CTRL_KEY_EN
    localparam bit KEYED = 1'b1;
`else
    localparam bit KEYED = 1'b0;
`endif

    logic         clk;
    logic         reset;
    logic         cfg_v_i;
    logic [6:0]   cfg_kk_i;
    logic [6:0]   cfg_nn_i;
    logic [31:0]  cfg_mlen_i;
    logic         cfg_slow_i;
    logic         cfg_err_o;
    logic         s_valid_i;
    logic         s_ready_o;
    logic [7:0]   s_data_i;
    logic         core_nreset_o;
    logic [6:0]   core_kk_o;
    logic [6:0]   core_nn_o;
    logic [127:0] core_ll_o;
    logic         core_slow_output_o;
    logic         core_block_first_o;
    logic         core_block_last_o;
    logic         core_data_v_o;
    logic [6:0]   core_data_idx_o;
    logic [7:0]   core_data_o;
    logic         core_ready_v_i;
    logic         core_h_v_i;
    logic [7:0]   core_h_i;
    logic         h_v_o;
    logic [7:0]   h_o;
    logic         h_last_o;
    logic         busy_o;

    blake2_ctrl dut (
        .clk                (clk),
        .reset              (reset),
        .cfg_v_i            (cfg_v_i),
        .cfg_kk_i           (cfg_kk_i),
        .cfg_nn_i           (cfg_nn_i),
        .cfg_mlen_i         (cfg_mlen_i),
        .cfg_slow_i         (cfg_slow_i),
        .cfg_err_o          (cfg_err_o),
        .s_valid_i          (s_valid_i),
        .s_ready_o          (s_ready_o),
        .s_data_i           (s_data_i),
        .core_nreset_o      (core_nreset_o),
        .core_kk_o          (core_kk_o),
        .core_nn_o          (core_nn_o),
        .core_ll_o          (core_ll_o),
        .core_slow_output_o (core_slow_output_o),
        .core_block_first_o (core_block_first_o),
        .core_block_last_o  (core_block_last_o),
        .core_data_v_o      (core_data_v_o),
        .core_data_idx_o    (core_data_idx_o),
        .core_data_o        (core_data_o),
        .core_ready_v_i     (core_ready_v_i),
        .core_h_v_i         (core_h_v_i),
        .core_h_i           (core_h_i),
        .h_v_o              (h_v_o),
        .h_o                (h_o),
        .h_last_o           (h_last_o),
        .busy_o             (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [7:0] d;
        int         idx;
        bit         first;
        bit         last;
        bit         src;
    } tx_t;

    typedef struct {
        int kk;
        int nn;
        int mlen;
        bit slow;
        bit err;
    } vec_t;

    tx_t        txq[$];
    logic [7:0] stream[$];
    logic [7:0] dig[$];

    // Expected block transfers: key block (if any) padded to BB,
    // then message padded to whole blocks (at least one if unkeyed).
    task automatic build_job(input int kk, input int nn, input int mlen);
        int  mb;
        int  tot;
        int  b;
        int  p;
        tx_t t;
        stream.delete();
        txq.delete();
        dig.delete();
        for (int i = 0; i < kk; i++) stream.push_back(8'($urandom));
        for (int i = 0; i < mlen; i++) begin
            if (mlen == 3)
                stream.push_back(i == 0 ? 8'h61 : (i == 1 ? 8'h62 : 8'h63));
            else
                stream.push_back(8'($urandom));
        end
        for (int i = 0; i < nn; i++) dig.push_back(8'($urandom));
        mb = (mlen + BB - 1) / BB;
        if (kk == 0 && mb == 0) mb = 1;
        tot = mb + ((kk != 0) ? 1 : 0);
        b = 0;
        if (kk != 0) begin
            for (int i = 0; i < BB; i++) begin
                t.src   = (i < kk);
                t.d     = t.src ? stream[i] : 8'h00;
                t.idx   = i;
                t.first = 1'b1;
                t.last  = (tot == 1);
                txq.push_back(t);
            end
            b = 1;
        end
        for (int m = 0; m < mb; m++) begin
            for (int i = 0; i < BB; i++) begin
                p       = m * BB + i;
                t.src   = (p < mlen);
                t.d     = t.src ? stream[kk + p] : 8'h00;
                t.idx   = i;
                t.first = (b == 0);
                t.last  = (b == tot - 1);
                txq.push_back(t);
            end
            b++;
        end
    endtask

    task automatic check_err(input int kk, input int nn, input int mlen,
                             input string tag);
        @(negedge clk);
        cfg_v_i    = 1'b1;
        cfg_kk_i   = 7'(kk);
        cfg_nn_i   = 7'(nn);
        cfg_mlen_i = mlen;
        @(negedge clk);
        cfg_v_i = 1'b0;
        #1;
        chk({tag, " err_pulse"}, 64'(cfg_err_o), 64'(1));
        chk({tag, " err_busy"}, 64'(busy_o), 64'(0));
        @(negedge clk);
        #1;
        chk({tag, " err_drop"}, 64'(cfg_err_o), 64'(0));
    endtask

    task automatic run_job(input int kk, input int nn, input int mlen,
                           input bit slow, input string tag);
        int tp;
        int sp;
        int cyc;
        int lead;
        int step;
        int j;
        int gap;
        bit exp_src;
        bit exp_dv;
        bit exp_hv;
        build_job(kk, nn, mlen);
        @(negedge clk);
        cfg_v_i        = 1'b1;
        cfg_kk_i       = 7'(kk);
        cfg_nn_i       = 7'(nn);
        cfg_mlen_i     = mlen;
        cfg_slow_i     = slow;
        core_ready_v_i = 1'b0;
        s_valid_i      = 1'b0;
        @(negedge clk);
        cfg_v_i = 1'b0;
        #1;
        chk({tag, " busy"}, 64'(busy_o), 64'(1));
        chk({tag, " ll"}, 64'(core_ll_o),
            64'(mlen + ((kk != 0) ? BB : 0)));
        chk({tag, " kk_nn_slow"},
            64'({core_kk_o, core_nn_o, core_slow_output_o}),
            64'({7'(KEYED ? kk : 0), 7'(nn), slow}));
        tp  = 0;
        sp  = 0;
        cyc = 0;
        while (tp < txq.size() && cyc < 20 * txq.size() + 200) begin
            @(negedge clk);
            cyc++;
            core_ready_v_i = ($urandom_range(0, 3) != 0);
            s_valid_i      = ($urandom_range(0, 3) != 0);
            s_data_i       = (sp < stream.size()) ? stream[sp]
                                                  : 8'($urandom);
            // valid-looking configs while busy must be ignored
            cfg_v_i    = ($urandom_range(0, 7) == 0);
            cfg_nn_i   = (nn == 1) ? 7'd2 : 7'd1;
            cfg_mlen_i = $urandom;
            #1;
            exp_src = txq[tp].src;
            exp_dv  = core_ready_v_i && (!exp_src || s_valid_i);
            chk({tag, " s_ready"}, 64'(s_ready_o),
                64'(core_ready_v_i && exp_src));
            chk({tag, " data_v"}, 64'(core_data_v_o), 64'(exp_dv));
            chk({tag, " no_err"}, 64'(cfg_err_o), 64'(0));
            if (exp_dv) begin
                chk({tag, " beat"},
                    64'({core_data_o, core_data_idx_o,
                         core_block_first_o, core_block_last_o}),
                    64'({txq[tp].d, 7'(txq[tp].idx),
                         txq[tp].first, txq[tp].last}));
                tp++;
                if (exp_src) sp++;
            end
        end
        cfg_v_i = 1'b0;
        chk({tag, " feed_done"}, 64'(tp), 64'(txq.size()));
        gap = $urandom_range(1, 4);
        for (int g = 0; g < gap; g++) begin
            @(negedge clk);
            core_ready_v_i = 1'b1;
            s_valid_i      = 1'b1;
            core_h_v_i     = 1'b0;
            #1;
            chk({tag, " wait_quiet"},
                64'({s_ready_o, core_data_v_o, h_v_o, busy_o}),
                64'(4'b0001));
        end
        chk({tag, " nn_held"}, 64'(core_nn_o), 64'(nn));
        lead = slow ? 2 : 1;
        step = slow ? 2 : 1;
        for (int c = 0; c <= lead + nn * step + 2; c++) begin
            @(negedge clk);
            core_ready_v_i = 1'b0;
            s_valid_i      = 1'b0;
            core_h_v_i     = (c < lead + nn * step);
            core_h_i       = (c >= lead && c < lead + nn * step)
                             ? dig[(c - lead) / step] : 8'($urandom);
            #1;
            j      = c - 1 - lead;
            exp_hv = (j >= 0) && (j % step == 0) && (j / step < nn);
            chk({tag, " h_v"}, 64'(h_v_o), 64'(exp_hv));
            if (exp_hv) begin
                chk({tag, " h_byte"}, 64'({h_o, h_last_o}),
                    64'({dig[j / step], (j / step == nn - 1)}));
            end
        end
        core_h_v_i = 1'b0;
        chk({tag, " idle"}, 64'(busy_o), 64'(0));
    endtask

    task automatic check_reset_outs(input string tag);
        chk({tag, " ctl_zero"},
            64'({s_ready_o, core_data_v_o, busy_o, cfg_err_o, h_v_o,
                 h_last_o, core_block_first_o, core_block_last_o,
                 core_slow_output_o, core_nreset_o, |core_ll_o}),
            64'(0));
        chk({tag, " bus_zero"},
            64'({core_nn_o, core_kk_o, core_data_idx_o, core_data_o, h_o}),
            64'(0));
    endtask

    task automatic release_reset(input string tag);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk({tag, " nrst_0clk"}, 64'(core_nreset_o), 64'(0));
        @(negedge clk);
        #1;
        chk({tag, " nrst_1clk"}, 64'(core_nreset_o), 64'(0));
        @(negedge clk);
        #1;
        chk({tag, " nrst_2clk"}, 64'(core_nreset_o), 64'(1));
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vt[12];
        bit   hit;
        int   rk;
        vt[0]  = '{0, 64, 0, 1'b0, 1'b0};
        vt[1]  = '{0, 64, 3, 1'b0, 1'b0};
        vt[2]  = '{0, 32, 256, 1'b0, 1'b0};
        vt[3]  = '{64, 64, 0, 1'b0, !KEYED};
        vt[4]  = '{0, 4, 10, 1'b1, 1'b0};
        vt[5]  = '{0, 0, 5, 1'b0, 1'b1};
        vt[6]  = '{0, 65, 5, 1'b0, 1'b1};
        vt[7]  = '{65, 16, 5, 1'b0, 1'b1};
        vt[8]  = '{0, 1, 128, 1'b0, 1'b0};
        vt[9]  = '{0, 20, 129, 1'b1, 1'b0};
        vt[10] = '{5, 32, 200, 1'b0, !KEYED};
        vt[11] = '{1, 64, 127, 1'b1, !KEYED};

        reset          = 1'b1;
        cfg_v_i        = 1'b0;
        cfg_kk_i       = '0;
        cfg_nn_i       = '0;
        cfg_mlen_i     = '0;
        cfg_slow_i     = 1'b0;
        s_valid_i      = 1'b0;
        s_data_i       = '0;
        core_ready_v_i = 1'b0;
        core_h_v_i     = 1'b0;
        core_h_i       = '0;
        repeat (3) @(negedge clk);
        #1;
        check_reset_outs("por");
        release_reset("por");

        for (int v = 0; v < 12; v++) begin
            if (vt[v].err)
                check_err(vt[v].kk, vt[v].nn, vt[v].mlen,
                          $sformatf("vec%0d", v));
            else
                run_job(vt[v].kk, vt[v].nn, vt[v].mlen, vt[v].slow,
                        $sformatf("vec%0d", v));
        end

        for (int r = 0; r < 6; r++) begin
            rk = KEYED ? $urandom_range(0, 64) : 0;
            run_job(rk, $urandom_range(1, 64), $urandom_range(0, 300),
                    1'($urandom_range(0, 1)), $sformatf("rnd%0d", r));
        end

        // Reset in the middle of a message block.
        @(negedge clk);
        cfg_v_i    = 1'b1;
        cfg_kk_i   = '0;
        cfg_nn_i   = 7'd16;
        cfg_mlen_i = 300;
        cfg_slow_i = 1'b0;
        @(negedge clk);
        cfg_v_i        = 1'b0;
        core_ready_v_i = 1'b1;
        s_valid_i      = 1'b1;
        s_data_i       = 8'h5a;
        hit = 1'b0;
        for (int i = 0; i < 200 && !hit; i++) begin
            @(negedge clk);
            #1;
            if (core_data_idx_o == 7'd40) hit = 1'b1;
        end
        chk("mid idx40_reached", 64'(hit), 64'(1));
        #2;
        reset = 1'b1;
        #1;
        core_ready_v_i = 1'b0;
        s_valid_i      = 1'b0;
        #1;
        check_reset_outs("mid");
        release_reset("mid");
        run_job(0, 16, 40, 1'b1, "post");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
